// File: rtl/if_id_fetch_queue_pkg.sv
// Shared constants and types for the IF/ID fetch queue.
package if_id_fetch_queue_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

    localparam int unsigned FQ_DEPTH = 4;
    localparam int unsigned FQ_AW    = 2;

    // Link value offset for jal/jalr/bal: return past the delay slot.
    localparam int unsigned LINK_OFFSET = 8;

    typedef enum logic [1:0] {
        FqEmpty,
        FqPartial,
        FqFull
    } fq_state_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x DW register file: one synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents carry no reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// Decoupling queue between IF and ID: {pc, inst} pairs, valid/ready to ID, stall back to IF.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int unsigned W     = WORD_WIDTH,
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned AW    = FQ_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [W-1:0]  in_pc,
    input  logic [W-1:0]  in_inst,
    output logic          stall_if,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_pc,
    output logic [W-1:0]  out_inst,
    output logic [W-1:0]  out_pc_p8,
    output logic [AW:0]   count
);

    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    fq_state_e     state;
    logic          push, pop, we;
    logic [2*W-1:0] rdata;
    logic [W-1:0]   head_pc, head_inst;

    always_comb begin
        state = FqPartial;
        if (count_q == '0) begin
            state = FqEmpty;
        end else if (count_q == COUNT_FULL) begin
            state = FqFull;
        end
    end

    // Both flags come from registered occupancy, so a full queue refuses a push
    // even when ID pops in the same cycle.
    assign stall_if  = (state == FqFull);
    assign out_valid = (state != FqEmpty);
    assign push      = in_valid && !stall_if;
    assign pop       = out_valid && out_ready;
    assign we        = push && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DW    (2 * W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign {head_pc, head_inst} = rdata;

    // Stale storage is masked so an empty queue presents a NOP at pc 0.
    assign out_pc    = out_valid ? head_pc : W'(ZERO_WORD);
    assign out_inst  = out_valid ? head_inst : W'(ZERO_WORD);
    assign out_pc_p8 = out_pc + W'(LINK_OFFSET);
    assign count     = count_q;

endmodule
